membrane_integrator: RTL and testbench

//  Forward-Euler integrator for the membrane potential V; the stage directly downstream of sodiumCurrent.

---
 rtl/hh_pkg.sv | 22 ++
 rtl/membrane_integrator_if.sv | 25 ++
 rtl/spike_detector.sv | 38 +++
 rtl/membrane_integrator.sv | 115 +++++++++++
 tb/tb_membrane_integrator.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hh_pkg.sv
// Shared Q8.8 constants, FSM state type and helpers for the Hodgkin-Huxley pipeline stages.
package hh_pkg;

   localparam int unsigned QWidth = 16;
   localparam int unsigned QFrac  = 8;

   localparam logic signed [35:0] QRound = 36'sd128;

   localparam logic signed [15:0] VRest  = -16'sd16640;
   localparam logic signed [15:0] VMax   = 16'sd15360;
   localparam logic signed [15:0] VMin   = -16'sd25600;
   localparam logic signed [15:0] VTh    = 16'sd0;
   localparam logic signed [15:0] VHyst  = 16'sd2560;
   localparam logic signed [15:0] CmInv  = 16'sd256;

   typedef enum logic [1:0] {StIdle, StSum, StScale, StUpdate} state_e;

   function automatic logic signed [35:0] sext36(logic signed [15:0] x);
      return {{20{x[15]}}, x};
   endfunction

endpackage

// File: rtl/membrane_integrator_if.sv
// Current-set input and membrane-potential output bundle of the integrator.
interface membrane_integrator_if;

   logic signed [15:0] dt;
   logic signed [15:0] i_na;
   logic signed [15:0] i_k;
   logic signed [15:0] i_l;
   logic signed [15:0] i_ext;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] v_mem;
   logic               v_valid;
   logic               spike;

   modport master (
      output dt, i_na, i_k, i_l, i_ext, in_valid,
      input  in_ready, v_mem, v_valid, spike
   );

   modport slave (
      input  dt, i_na, i_k, i_l, i_ext, in_valid,
      output in_ready, v_mem, v_valid, spike
   );

endinterface

// File: rtl/spike_detector.sv
// Upward threshold-crossing detector with hysteresis re-arm; spike_o is valid only with upd_i.
module spike_detector
   import hh_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [15:0] v_old_i,
   input  logic signed [15:0] v_new_i,
   input  logic               upd_i,
   output logic               spike_o,
   output logic               armed_o
);

   localparam logic signed [15:0] VRearm = VTh - VHyst;

   logic armed_q, armed_d;

   assign spike_o = upd_i && armed_q && (v_old_i < VTh) && (v_new_i >= VTh);
   assign armed_o = armed_q;

   always_comb begin
      armed_d = armed_q;
      if (spike_o) begin
         armed_d = 1'b0;
      end else if (upd_i && (v_new_i < VRearm)) begin
         armed_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b1;
      end else begin
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/membrane_integrator.sv
// Forward-Euler membrane potential integrator: V += dt*CmInv*(I_ext-I_na-I_k-I_l), saturating.
// Optional SPIKE_COUNT_EN adds a wrapping 16-bit spike counter output.
module membrane_integrator
   import hh_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef SPIKE_COUNT_EN
   output logic [15:0]          spike_count_o,
`endif
   membrane_integrator_if.slave bus
);

   localparam logic signed [35:0] CmInvW = 36'(CmInv);
   localparam logic signed [35:0] VMaxW  = 36'(VMax);
   localparam logic signed [35:0] VMinW  = 36'(VMin);

   state_e state_q, state_d;

   logic signed [15:0] dt_q, na_q, k_q, l_q, ext_q, v_q, v_new;
   logic signed [17:0] sum_q, sum_d;
   logic signed [35:0] delta_q, delta_d, prod, scaled, nv_full;
   logic               v_valid_q, spike_q, accept, upd, spike_hit, armed;

   assign accept = bus.in_valid && (state_q == StIdle);
   assign upd    = (state_q == StUpdate);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StSum;
         StSum:    state_d = StScale;
         StScale:  state_d = StUpdate;
         StUpdate: state_d = StIdle;
      endcase
   end

   // 18 bits hold the worst case of four 16-bit terms without overflow.
   assign sum_d = $signed({{2{ext_q[15]}}, ext_q}) - $signed({{2{na_q[15]}}, na_q})
                - $signed({{2{k_q[15]}}, k_q}) - $signed({{2{l_q[15]}}, l_q});

   assign prod    = $signed({{18{sum_q[17]}}, sum_q}) * sext36(dt_q);
   assign scaled  = ((prod + QRound) >>> QFrac) * CmInvW;
   assign delta_d = (scaled + QRound) >>> QFrac;
   assign nv_full = sext36(v_q) + delta_q;

   always_comb begin
      v_new = nv_full[15:0];
      if (nv_full > VMaxW) begin
         v_new = VMax;
      end else if (nv_full < VMinW) begin
         v_new = VMin;
      end
   end

   spike_detector u_spike_detector (
      .clk     (clk),
      .rst_n   (rst_n),
      .v_old_i (v_q),
      .v_new_i (v_new),
      .upd_i   (upd),
      .spike_o (spike_hit),
      .armed_o (armed)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         dt_q      <= '0;
         na_q      <= '0;
         k_q       <= '0;
         l_q       <= '0;
         ext_q     <= '0;
         sum_q     <= '0;
         delta_q   <= '0;
         v_q       <= VRest;
         v_valid_q <= 1'b0;
         spike_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         v_valid_q <= upd;
         spike_q   <= spike_hit;
         if (accept) begin
            dt_q  <= bus.dt;
            na_q  <= bus.i_na;
            k_q   <= bus.i_k;
            l_q   <= bus.i_l;
            ext_q <= bus.i_ext;
         end
         if (state_q == StSum)   sum_q   <= sum_d;
         if (state_q == StScale) delta_q <= delta_d;
         if (upd)                v_q     <= v_new;
      end
   end

`ifdef SPIKE_COUNT_EN
   logic [15:0] spike_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_count_q <= '0;
      end else if (spike_hit) begin
         spike_count_q <= spike_count_q + 16'd1;
      end
   end

   assign spike_count_o = spike_count_q;
`endif

   assign bus.in_ready = (state_q == StIdle);
   assign bus.v_mem    = v_q;
   assign bus.v_valid  = v_valid_q;
   assign bus.spike    = spike_q;

endmodule

// File: tb/tb_membrane_integrator.sv
// Self-checking bench: transaction-level model of the integrator checked every cycle.
module tb_membrane_integrator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   membrane_integrator_if mi ();
`ifdef SPIKE_COUNT_EN
   logic [15:0] spike_count;
`endif

   membrane_integrator dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef SPIKE_COUNT_EN
      .spike_count_o (spike_count),
`endif
      .bus           (mi)
   );

   int total = 0;
   int bad = 0;

   // Model state: potential, arming, steps pending, expected pulses.
   longint m_v = -16640;
   longint m_pend = 0;
   bit     m_armed = 1'b1;
   int     m_cnt = 0;
   int     m_spikes = 0;
   bit     e_valid = 1'b0;
   bit     e_spike = 1'b0;
   bit     e_ready = 1'b1;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint model_step(input longint v, input longint ext, input longint na,
                                         input longint k, input longint l, input longint dt);
      longint s, p, d, n;
      s = ext - na - k - l;
      p = (s * dt + 128) >>> 8;
      d = (p * 256 + 128) >>> 8;
      n = v + d;
      if (n > 15360) n = 15360;
      if (n < -25600) n = -25600;
      return n;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_v = -16640; m_armed = 1'b1; m_cnt = 0; m_spikes = 0;
         e_valid = 1'b0; e_spike = 1'b0; e_ready = 1'b1;
      end else begin
         e_valid = 1'b0;
         e_spike = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               e_valid = 1'b1;
               e_spike = m_armed && (m_v < 0) && (m_pend >= 0);
               if (e_spike) begin
                  m_armed = 1'b0;
                  m_spikes++;
               end else if (m_pend < -2560) begin
                  m_armed = 1'b1;
               end
               m_v = m_pend;
            end
         end else if (mi.in_valid) begin
            m_pend = model_step(m_v, mi.i_ext, mi.i_na, mi.i_k, mi.i_l, mi.dt);
            m_cnt = 3;
         end
         e_ready = (m_cnt == 0);
      end
   end

   initial forever begin
      @(negedge clk);
      chk("v_mem", mi.v_mem, m_v);
      chk("v_valid", mi.v_valid, e_valid);
      chk("spike", mi.spike, e_spike);
      chk("in_ready", mi.in_ready, e_ready);
`ifdef SPIKE_COUNT_EN
      chk("spike_count", spike_count, m_spikes % 65536);
`endif
   end

   task automatic set_in(input int ext, input int na, input int k, input int l, input int dt);
      mi.i_ext = 16'(ext); mi.i_na = 16'(na); mi.i_k = 16'(k); mi.i_l = 16'(l); mi.dt = 16'(dt);
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_v_mem", mi.v_mem, -16640);
      chk("rst_v_valid", mi.v_valid, 0);
      chk("rst_spike", mi.spike, 0);
      chk("rst_in_ready", mi.in_ready, 1);
      mi.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input int ext, input int na, input int k, input int l, input int dt,
                       output logic sp, output longint v);
      int n;
      @(negedge clk);
      set_in(ext, na, k, l, dt);
      mi.in_valid = 1'b1;
      n = 0;
      while (!mi.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("accept_timeout", n, 0);
      @(negedge clk);
      mi.in_valid = 1'b0;
      set_in($urandom, $urandom, $urandom, $urandom, $urandom);
      n = 0;
      while (!mi.v_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) chk("update_timeout", n, 0);
      sp = mi.spike;
      v = mi.v_mem;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic   sp;
      longint v;
      int     acc[$];

      mi.in_valid = 1'b0;
      set_in(0, 0, 0, 0, 0);

      chk("model_basic", model_step(-16640, 256, 0, 0, 0, 256), -16384);
      chk("model_round", model_step(-16640, 0, 3, 0, 0, 128), -16641);

      reset_dut();

      // Reset abandons an in-flight step.
      @(negedge clk);
      set_in(32767, 0, 0, 0, 256);
      mi.in_valid = 1'b1;
      @(negedge clk);
      mi.in_valid = 1'b0;
      reset_dut();
      repeat (6) @(negedge clk);
      chk("no_update_after_rst", mi.v_mem, -16640);

      step(256, 0, 0, 0, 256, sp, v);
      chk("basic_v", v, -16384);
      chk("basic_spike", sp, 0);
      @(negedge clk);
      chk("basic_valid_pulse", mi.v_valid, 0);

      reset_dut();
      step(0, 3, 0, 0, 128, sp, v);
      chk("round_v", v, -16641);

      reset_dut();
      step(31640, 0, 0, 0, 256, sp, v);
      chk("sat_pre", v, 15000);
      step(32767, 0, 0, 0, 256, sp, v);
      chk("sat_max", v, 15360);
      step(0, 32767, 0, 0, 256, sp, v);
      step(0, 7593, 0, 0, 256, sp, v);
      chk("sat_pre_low", v, -25000);
      step(0, 32767, 0, 0, 256, sp, v);
      chk("sat_min", v, -25600);

      reset_dut();
      step(16384, 0, 0, 0, 256, sp, v);
      chk("hyst_v0", v, -256);
      step(512, 0, 0, 0, 256, sp, v);
      chk("hyst_spike1", sp, 1);
      step(0, 512, 0, 0, 256, sp, v);
      step(512, 0, 0, 0, 256, sp, v);
      chk("hyst_disarmed", sp, 0);
      step(0, 4096, 0, 0, 256, sp, v);
      chk("hyst_low", v, -3840);
      step(4096, 0, 0, 0, 256, sp, v);
      chk("hyst_spike2", sp, 1);
      step(0, 4096, 0, 0, 256, sp, v);
      step(4096, 0, 0, 0, 256, sp, v);
      chk("hyst_spike3", sp, 1);
`ifdef SPIKE_COUNT_EN
      @(negedge clk);
      chk("spike_count_3", spike_count, 3);
`endif

      // Continuous in_valid with inputs changing every cycle.
      reset_dut();
      @(negedge clk);
      set_in(100, 0, 0, 0, 256);
      mi.in_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (i > 0) @(negedge clk);
         if (mi.in_ready) acc.push_back(i);
         set_in($urandom_range(0, 2000), $urandom_range(0, 2000), 0, 0, $urandom_range(0, 512));
      end
      mi.in_valid = 1'b0;
      chk("accept_count", acc.size(), 6);
      for (int i = 1; i < acc.size(); i++) chk("accept_gap", acc[i] - acc[i-1], 4);
      repeat (5) @(negedge clk);

      // Random traffic.
      reset_dut();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         mi.in_valid = ($urandom_range(0, 3) != 0);
         set_in($urandom, $urandom, $urandom_range(0, 1) ? $urandom : 0,
                $urandom_range(0, 1) ? $urandom : 0, $urandom_range(0, 200));
      end
      mi.in_valid = 1'b0;
      repeat (6) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
